// File: rtl/pipe_issue_ctrl.sv
// Issue/credit controller for a fixed-latency, non-stallable datapath with an output FIFO.
// Optional statistics counters are enabled with PIPE_ISSUE_CTRL_STATS_EN.
module pipe_issue_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned OUT_DEPTH  = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               s_valid_i,
    output logic                               s_ready_o,
    output logic                               pipe_en_o,
    input  logic [DATA_WIDTH-1:0]              pipe_data_i,
    output logic                               m_valid_o,
    output logic [DATA_WIDTH-1:0]              m_data_o,
    input  logic                               m_ready_i,
    input  logic                               flush_i,
    output logic                               flush_done_o,
    output logic                               busy_o,
    output logic [$clog2(OUT_DEPTH+1)-1:0]     occ_o
`ifdef PIPE_ISSUE_CTRL_STATS_EN
    ,
    output logic [31:0]                        stat_issue_o,
    output logic [31:0]                        stat_stall_o,
    output logic [31:0]                        stat_hold_o
`endif
);

    localparam int unsigned OCC_W = $clog2(OUT_DEPTH + 1);
    localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t                 state, state_next;
    logic [LATENCY-1:0]     vline, vline_next;
    logic [OCC_W-1:0]       occ, occ_next;
    logic [OCC_W-1:0]       cnt, cnt_next;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr, wr_next, rd_next;
    logic [DATA_WIDTH-1:0]  mem [OUT_DEPTH];
    logic [DATA_WIDTH-1:0]  head_next;
    logic                   capture;
    logic                   pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pipe_en_o = s_valid_i & s_ready_o;
    assign pop       = m_valid_o & m_ready_i;
    assign capture   = vline[LATENCY-1];
    assign occ_o     = occ;

    // Next state, occupancy, pointers and the registered FIFO head.
    always_comb begin
        state_next = state;
        vline_next = LATENCY'({vline, pipe_en_o});
        occ_next   = occ + OCC_W'(pipe_en_o) - OCC_W'(pop);
        cnt_next   = cnt + OCC_W'(capture) - OCC_W'(pop);
        wr_next    = capture ? ptr_inc(wr_ptr) : wr_ptr;
        rd_next    = pop ? ptr_inc(rd_ptr) : rd_ptr;
        head_next  = '0;
        case (state)
            RUN:     if (flush_i) state_next = DRAIN;
            DRAIN:   if (occ == '0) state_next = DONE;
            DONE:    state_next = RUN;
            default: state_next = RUN;
        endcase
        // A write landing on the new head bypasses the memory.
        if (cnt_next != '0) begin
            head_next = (capture && (wr_ptr == rd_next)) ? pipe_data_i : mem[rd_next];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= RUN;
            vline        <= '0;
            occ          <= '0;
            cnt          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            s_ready_o    <= 1'b1;
            m_valid_o    <= 1'b0;
            m_data_o     <= '0;
            flush_done_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state        <= state_next;
            vline        <= vline_next;
            occ          <= occ_next;
            cnt          <= cnt_next;
            wr_ptr       <= wr_next;
            rd_ptr       <= rd_next;
            s_ready_o    <= (state_next == RUN) && (occ_next < OCC_W'(OUT_DEPTH));
            m_valid_o    <= (cnt_next != '0);
            m_data_o     <= head_next;
            flush_done_o <= (state_next == DONE);
            busy_o       <= (occ_next != '0);
        end
    end

    // FIFO storage needs no reset; validity lives in cnt.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            mem[wr_ptr] <= pipe_data_i;
        end
    end

`ifdef PIPE_ISSUE_CTRL_STATS_EN
    // Saturating event counters, untouched by flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_issue_o <= '0;
            stat_stall_o <= '0;
            stat_hold_o  <= '0;
        end else begin
            if (pipe_en_o && (stat_issue_o != '1)) begin
                stat_issue_o <= stat_issue_o + 32'd1;
            end
            if (s_valid_i && !s_ready_o && (stat_stall_o != '1)) begin
                stat_stall_o <= stat_stall_o + 32'd1;
            end
            if (m_valid_o && !m_ready_i && (stat_hold_o != '1)) begin
                stat_hold_o <= stat_hold_o + 32'd1;
            end
        end
    end
`endif

endmodule
